svi_cas_fsk_player: RTL and testbench

Plays a CAS tape image held in on-chip RAM as an SVI-328 FSK cassette signal. It sits between the CAS image RAM and the console's tape input (`svi_tap_i`). It fetches image bytes in order and frames each one as serial bits. Each bit is emitted as 1200/2400 Hz square-wave cycles while the console's motor line enables playback. It also exports a byte counter for an on-screen tape counter.

---
 rtl/svi_tape_pkg.sv | 26 ++
 rtl/svi_cas_fsk_player_if.sv | 21 ++
 rtl/svi_fsk_bit_gen.sv | 76 +++++++
 rtl/svi_cas_fsk_player.sv | 173 +++++++++++++++++
 tb/tb_svi_cas_fsk_player.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/svi_tape_pkg.sv
// Shared types and timing helpers for the SVI-328 cassette FSK player.
// Half-period lengths are derived from the clock and bit rate, truncated.
package svi_tape_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tape_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 2;

  // Half-period of the BAUD Hz tone used for a 0 bit
  function automatic int unsigned half_period_0(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (2 * baud);
  endfunction

  // Half-period of the 2*BAUD Hz tone used for a 1 bit
  function automatic int unsigned half_period_1(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (4 * baud);
  endfunction

endpackage

// File: rtl/svi_cas_fsk_player_if.sv
// Read port between the cassette player and the CAS image RAM.
// Data is expected one clock after the read strobe.
interface svi_cas_fsk_player_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_rd_o;
  logic [7:0]        ram_data_i;

  modport master (
    output ram_addr_o,
    output ram_rd_o,
    input  ram_data_i
  );

  modport slave (
    input  ram_addr_o,
    input  ram_rd_o,
    output ram_data_i
  );
endinterface

// File: rtl/svi_fsk_bit_gen.sv
// Produces the square-wave cycles of one tape bit: one BAUD cycle for a 0,
// two 2*BAUD cycles for a 1. done_o marks the last clock of the bit.
module svi_fsk_bit_gen
  import svi_tape_pkg::*;
#(
  parameter int unsigned CLK_HZ = 42666000,
  parameter int unsigned BAUD   = 1200
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic bit_i,
  input  logic hold_i,
  input  logic clear_i,
  output logic wave_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned H0    = half_period_0(CLK_HZ, BAUD);
  localparam int unsigned H1    = half_period_1(CLK_HZ, BAUD);
  localparam int unsigned TMR_W = $clog2(H0 + 1);

  logic [TMR_W-1:0] tmr_q;
  logic [1:0]       half_q;
  logic             bit_q;
  logic             busy_q;
  logic             wave_q;
  logic             half_end;
  logic             last_half;

  assign half_end  = tmr_q == (bit_q ? TMR_W'(H1 - 1) : TMR_W'(H0 - 1));
  assign last_half = half_q == (bit_q ? 2'd3 : 2'd1);
  assign done_o    = busy_q && !hold_i && half_end && last_half;
  assign busy_o    = busy_q;
  assign wave_o    = wave_q;

  // A new start on the done clock chains the next bit with no gap
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmr_q  <= '0;
      half_q <= '0;
      bit_q  <= 1'b0;
      busy_q <= 1'b0;
      wave_q <= 1'b0;
    end else if (clear_i) begin
      tmr_q  <= '0;
      half_q <= '0;
      bit_q  <= 1'b0;
      busy_q <= 1'b0;
      wave_q <= 1'b0;
    end else if (!hold_i) begin
      if (start_i) begin
        tmr_q  <= '0;
        half_q <= '0;
        bit_q  <= bit_i;
        busy_q <= 1'b1;
        wave_q <= 1'b1;
      end else if (busy_q) begin
        if (half_end) begin
          tmr_q <= '0;
          if (last_half) begin
            busy_q <= 1'b0;
            wave_q <= 1'b0;
          end else begin
            half_q <= half_q + 2'd1;
            wave_q <= ~wave_q;
          end
        end else begin
          tmr_q <= tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/svi_cas_fsk_player.sv
// Streams a CAS image from RAM as framed FSK bits (start, 8 data LSB first,
// 2 stop) to the SVI-328 tape input, pausing with the motor line.
module svi_cas_fsk_player
  import svi_tape_pkg::*;
#(
  parameter int unsigned CLK_HZ = 42666000,
  parameter int unsigned BAUD   = 1200,
  parameter int unsigned ADDR_W = 18
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 play_i,
  input  logic                 rewind_i,
  input  logic [ADDR_W:0]      length_i,
  svi_cas_fsk_player_if.master ram,
  output logic                 tape_o,
  output logic                 active_o,
  output logic                 eof_o,
  output logic [ADDR_W:0]      byte_count_o
);

  tape_state_e       state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              latch_q;
  logic              eof_q, eof_d;
  logic              active_q;
  logic [7:0]        shreg;
  logic              hold;
  logic              gen_start, gen_bit, gen_clear, gen_busy, gen_done;

  assign hold         = !play_i;
  assign byte_cnt_inc = byte_cnt_q + {{ADDR_W{1'b0}}, 1'b1};

  svi_fsk_bit_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_bit_gen (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (gen_start),
    .bit_i     (gen_bit),
    .hold_i    (hold),
    .clear_i   (gen_clear),
    .wave_o    (tape_o),
    .busy_o    (gen_busy),
    .done_o    (gen_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    eof_d      = eof_q;
    rd_d       = 1'b0;
    gen_start  = 1'b0;
    gen_bit    = 1'b0;
    gen_clear  = 1'b0;
    if (rewind_i) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      addr_d     = '0;
      eof_d      = 1'b0;
      gen_clear  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (play_i && !eof_q) begin
            if (byte_cnt_q < length_i) begin
              state_d = START;
              rd_d    = 1'b1;
              addr_d  = byte_cnt_q[ADDR_W-1:0];
            end else begin
              state_d = DONE;
              eof_d   = 1'b1;
            end
          end
        end
        // Entered from IDLE the generator is idle for one clock; entered
        // from STOP it was already started on the last stop-bit clock.
        START: begin
          if (!hold && !gen_busy) begin
            gen_start = 1'b1;
          end else if (gen_done) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            gen_start = 1'b1;
            gen_bit   = shreg[0];
          end
        end
        DATA: begin
          if (gen_done) begin
            gen_start = 1'b1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              state_d   = STOP;
              bit_cnt_d = '0;
              gen_bit   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              gen_bit   = shreg[bit_cnt_q + 3'd1];
            end
          end
        end
        STOP: begin
          if (gen_done) begin
            if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
              byte_cnt_d = byte_cnt_inc;
              bit_cnt_d  = '0;
              if (byte_cnt_inc < length_i) begin
                state_d   = START;
                rd_d      = 1'b1;
                addr_d    = byte_cnt_inc[ADDR_W-1:0];
                gen_start = 1'b1;
              end else begin
                state_d = DONE;
                eof_d   = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              gen_start = 1'b1;
              gen_bit   = 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      latch_q    <= 1'b0;
      eof_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      latch_q    <= rd_q && !rewind_i;
      eof_q      <= eof_d;
      active_q   <= (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end
  end

  // Latch follows the strobe unconditionally so a pause never drops a read
  always_ff @(posedge clk_i) begin
    if (rewind_i) begin
      shreg <= '0;
    end else if (latch_q) begin
      shreg <= ram.ram_data_i;
    end
  end

  assign ram.ram_addr_o = addr_q;
  assign ram.ram_rd_o   = rd_q;
  assign active_o       = active_q;
  assign eof_o          = eof_q;
  assign byte_count_o   = byte_cnt_q;

endmodule

// File: tb/tb_svi_cas_fsk_player.sv
// Bench for svi_cas_fsk_player at CLK_HZ=48000, BAUD=1200 (H0=20, H1=10):
// table vectors, randomized images against a waveform model, corner sequences.
module tb_svi_cas_fsk_player;
  localparam int unsigned CLK_HZ = 48000;
  localparam int unsigned BAUD   = 1200;
  localparam int unsigned ADDR_W = 8;
  localparam int H0 = 20;
  localparam int H1 = 10;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            play    = 1'b0;
  logic            rewind  = 1'b0;
  logic [ADDR_W:0] length  = '0;
  logic            tape, active, eof;
  logic [ADDR_W:0] bcnt;
  logic [7:0]      mem [256];

  svi_cas_fsk_player_if #(.ADDR_W(ADDR_W)) ram ();

  svi_cas_fsk_player #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .play_i       (play),
    .rewind_i     (rewind),
    .length_i     (length),
    .ram          (ram),
    .tape_o       (tape),
    .active_o     (active),
    .eof_o        (eof),
    .byte_count_o (bcnt)
  );

  always #5 clk = ~clk;

  // Image RAM: data one clock after the strobe, noise otherwise
  always @(posedge clk) ram.ram_data_i <= ram.ram_rd_o ? mem[ram.ram_addr_o] : 8'($urandom);

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Reference model: per-clock tape level for the whole image plus frame bounds
  logic [7:0] img [$];
  bit         wv [$];
  int         fstart [$];
  int         fend [$];

  task automatic build_model();
    wv.delete(); fstart.delete(); fend.delete();
    foreach (img[i]) begin
      logic [7:0] b;
      b = img[i];
      fstart.push_back(wv.size());
      for (int j = 0; j < 11; j++) begin
        bit v;
        v = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1;
        if (!v) begin
          repeat (H0) wv.push_back(1'b1);
          repeat (H0) wv.push_back(1'b0);
        end else begin
          repeat (2) begin
            repeat (H1) wv.push_back(1'b1);
            repeat (H1) wv.push_back(1'b0);
          end
        end
      end
      fend.push_back(wv.size());
    end
  endtask

  int              r_rises, r_first_rise, r_done_k;
  logic [ADDR_W:0] r_final_cnt;

  // Plays img from rewind; pp/plen describe an optional pause (plen=0: none)
  task automatic run_image(input string name, input int pp, input int plen);
    int n, total, kmax, u, s, xc, errs, kk;
    int fk, g_t, g_a, g_e, g_c, w_t, w_a, w_e, w_c;
    bit xt, xe, xa, ok, prev;
    int rd_k [$];
    int rd_a [$];
    n = img.size();
    total = wv.size();
    kmax = total + 8 + plen;
    for (int i = 0; i < n; i++) mem[i] = img[i];
    length = (ADDR_W+1)'(n);
    @(negedge clk); rewind = 1'b1; play = 1'b1;
    @(negedge clk);
    @(negedge clk); rewind = 1'b0;
    errs = 0; prev = 1'b0;
    fk = 0; g_t = 0; g_a = 0; g_e = 0; g_c = 0; w_t = 0; w_a = 0; w_e = 0; w_c = 0;
    r_rises = 0; r_first_rise = -1; r_done_k = -1;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      u = (plen == 0 || k <= pp) ? k : (k <= pp + plen) ? pp : k - plen;
      s = u - 2;
      xt = (s >= 0 && s < total) ? wv[s] : 1'b0;
      xc = 0;
      foreach (fend[f]) if (s >= fend[f]) xc++;
      xe = (s >= total);
      xa = (u >= 1) && !xe;
      if (tape !== xt || active !== xa || eof !== xe || int'(bcnt) != xc) begin
        if (errs == 0) begin
          fk = k; g_t = int'(tape); g_a = int'(active); g_e = int'(eof); g_c = int'(bcnt);
          w_t = int'(xt); w_a = int'(xa); w_e = int'(xe); w_c = xc;
        end
        errs++;
      end
      if (tape && !prev) begin
        r_rises++;
        if (r_first_rise < 0) r_first_rise = k;
      end
      prev = tape;
      if (eof && r_done_k < 0) r_done_k = k;
      if (ram.ram_rd_o) begin
        rd_k.push_back(k);
        rd_a.push_back(int'(ram.ram_addr_o));
      end
      if (plen > 0 && k == pp) play = 1'b0;
      if (plen > 0 && k == pp + plen) play = 1'b1;
    end
    r_final_cnt = bcnt;
    checks_total++;
    if (errs == 0) checks_passed++;
    else $display("FAIL %s trace: %0d bad clocks, first k=%0d got tape/act/eof/cnt=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  name, errs, fk, g_t, g_a, g_e, g_c, w_t, w_a, w_e, w_c);
    ok = (rd_k.size() == n);
    for (int f = 0; f < n && f < rd_k.size(); f++) begin
      kk = (f == 0) ? 1 : 2 + fstart[f];
      if (plen > 0 && kk > pp) kk += plen;
      if (rd_k[f] != kk || rd_a[f] != f) ok = 1'b0;
    end
    checks_total++;
    if (ok) checks_passed++;
    else $display("FAIL %s reads: got %0d reads first k=%0d addr=%0d, want %0d reads first k=1 addr=0",
                  name, rd_k.size(), (rd_k.size() > 0) ? rd_k[0] : -1,
                  (rd_a.size() > 0) ? rd_a[0] : -1, n);
  endtask

  typedef struct {
    logic [7:0] data;
    int         rises;
    int         done_k;
  } vec_t;

  vec_t tv [5];

  initial begin
    int n, pp, plen, cnt_rd, cnt_hi;
    tv[0] = '{8'h55, 17, 442};
    tv[1] = '{8'h00, 13, 442};
    tv[2] = '{8'hFF, 21, 442};
    tv[3] = '{8'h80, 14, 442};
    tv[4] = '{8'h0F, 17, 442};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tape", tape, 0);
    check("reset rd", ram.ram_rd_o, 0);
    check("reset addr", ram.ram_addr_o, 0);
    check("reset active", active, 0);
    check("reset eof", eof, 0);
    check("reset cnt", bcnt, 0);
    reset_n = 1'b1;

    // Single-byte vectors
    for (int i = 0; i < 5; i++) begin
      img = '{tv[i].data};
      build_model();
      run_image($sformatf("vec%0d", i), 0, 0);
      check($sformatf("vec%0d rises", i), r_rises, tv[i].rises);
      check($sformatf("vec%0d first rise", i), r_first_rise, 2);
      check($sformatf("vec%0d eof at", i), r_done_k, tv[i].done_k);
      check($sformatf("vec%0d final cnt", i), r_final_cnt, 1);
      check($sformatf("vec%0d tape after", i), tape, 0);
    end

    // Back-to-back frames
    img = '{8'h00, 8'hFF};
    build_model();
    run_image("b2b", 0, 0);
    check("b2b eof at", r_done_k, 882);
    check("b2b final cnt", r_final_cnt, 2);

    // Pause of 37 clocks mid-DATA of 0xA5
    img = '{8'hA5};
    build_model();
    run_image("pause", 169, 37);
    check("pause eof at", r_done_k, 442 + 37);

    // Randomized images, some with a random pause
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      build_model();
      pp = (r % 2 == 1) ? $urandom_range(2, n * 440) : 0;
      plen = (pp > 0) ? $urandom_range(1, 50) : 0;
      run_image($sformatf("rand%0d", r), pp, plen);
    end

    // Rewind mid-STOP of byte 3 with play held high
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    length = 9'd4;
    @(negedge clk); rewind = 1'b1; play = 1'b1;
    @(negedge clk);
    @(negedge clk); rewind = 1'b0;
    repeat (1262) @(negedge clk);
    check("rew pre cnt", bcnt, 2);
    check("rew pre active", active, 1);
    rewind = 1'b1;
    @(negedge clk);
    check("rew active", active, 0);
    check("rew cnt", bcnt, 0);
    check("rew tape", tape, 0);
    check("rew eof", eof, 0);
    repeat (2) @(negedge clk);
    check("rew held active", active, 0);
    rewind = 1'b0;
    @(negedge clk);
    check("rew reread rd", ram.ram_rd_o, 1);
    check("rew reread addr", ram.ram_addr_o, 0);

    // Empty image
    length = '0;
    @(negedge clk); rewind = 1'b1; play = 1'b1;
    @(negedge clk);
    @(negedge clk); rewind = 1'b0;
    check("empty eof pre", eof, 0);
    @(negedge clk);
    check("empty eof", eof, 1);
    check("empty active", active, 0);
    cnt_rd = int'(ram.ram_rd_o);
    cnt_hi = int'(tape);
    repeat (20) begin
      @(negedge clk);
      cnt_rd += int'(ram.ram_rd_o);
      cnt_hi += int'(tape);
    end
    check("empty reads", cnt_rd, 0);
    check("empty tape", cnt_hi, 0);

    // Asynchronous reset mid-byte, between clock edges
    mem[0] = 8'h3C;
    length = 9'd1;
    @(negedge clk); rewind = 1'b1; play = 1'b1;
    @(negedge clk);
    @(negedge clk); rewind = 1'b0;
    repeat (60) @(negedge clk);
    check("areset pre active", active, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("areset tape", tape, 0);
    check("areset active", active, 0);
    check("areset eof", eof, 0);
    check("areset cnt", bcnt, 0);
    check("areset rd", ram.ram_rd_o, 0);
    check("areset addr", ram.ram_addr_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    play = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
